code_to_number_parser: RTL and testbench

- Converts an ASCII character stream back into numbers: the inverse of the digit-to-ASCII encoder used on the display/UART path.
- Accepts bytes over a valid/ready handshake and accumulates decimal digits '0'-'9'.
- On a separator (space 8'h20 or CR 8'h0D), presents the parsed value in binary and BCD forms over a valid/ack handshake.
- Sits between the UART/keypad byte source and the control logic that consumes numeric entries.

---
 rtl/code_to_number_parser_pkg.sv | 25 ++
 rtl/code_to_number_parser_code_to_digit.sv | 31 +++
 rtl/code_to_number_parser.sv | 138 +++++++++++++
 tb/tb_code_to_number_parser.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/code_to_number_parser_pkg.sv
// Shared ASCII constants, parser state encoding and byte-class helpers
// used by the code-to-number parser and its character classifier.
package code_to_number_parser_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10,
    SKIP  = 2'b11
  } parser_state_t;

  function automatic logic is_digit_code(input logic [7:0] code);
    return (code >= ASCII_ZERO) && (code <= ASCII_NINE);
  endfunction

  function automatic logic is_term_code(input logic [7:0] code);
    return (code == ASCII_SPACE) || (code == ASCII_CR);
  endfunction

endpackage

// File: rtl/code_to_number_parser_code_to_digit.sv
// Combinational byte classifier: flags decimal digits and field separators
// and extracts the digit value (zero for non-digits).
module code_to_digit
  import code_to_number_parser_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] value
);

  // Classify the byte; the low nibble of '0'..'9' is the digit value.
  always_comb begin
    is_digit = 1'b0;
    is_term  = 1'b0;
    value    = 4'd0;
    if (is_digit_code(code)) begin
      is_digit = 1'b1;
      value    = code[3:0];
    end else begin
      is_digit = 1'b0;
      value    = 4'd0;
    end
    if (is_term_code(code)) begin
      is_term = 1'b1;
    end else begin
      is_term = 1'b0;
    end
  end

endmodule

// File: rtl/code_to_number_parser.sv
// Parses an ASCII byte stream into decimal fields, presenting each field's
// binary value, BCD digits and digit count over a valid/ack handshake.
module code_to_number_parser
  import code_to_number_parser_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int VAL_W      = 14,
  parameter int CNT_W      = 3
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic [7:0]              CODE,
  input  logic                    CODE_VALID,
  output logic                    CODE_READY,
  output logic [VAL_W-1:0]        NUMBER,
  output logic [4*MAX_DIGITS-1:0] DIGITS,
  output logic [CNT_W-1:0]        DIGIT_COUNT,
  output logic                    NUM_VALID,
  input  logic                    NUM_ACK,
  output logic                    ERROR
);

  parser_state_t           state_r;
  logic [VAL_W-1:0]        number_r;
  logic [4*MAX_DIGITS-1:0] digits_r;
  logic [CNT_W-1:0]        count_r;
  logic                    num_valid_r;
  logic                    error_r;

  logic                    is_digit_s;
  logic                    is_term_s;
  logic [3:0]              value_s;
  logic                    acc_s;
  logic                    count_full_s;
  logic [VAL_W-1:0]        next_number_s;
  logic [4*MAX_DIGITS-1:0] next_digits_s;
  logic [VAL_W-1:0]        first_number_s;
  logic [4*MAX_DIGITS-1:0] first_digits_s;

  // Shift-and-add times ten; parameter constraints rule out overflow.
  function automatic logic [VAL_W-1:0] mul10_add(input logic [VAL_W-1:0] n,
                                                 input logic [3:0]       d);
    return (n << 3) + (n << 1) + {{(VAL_W-4){1'b0}}, d};
  endfunction

  code_to_digit u_code_to_digit (
    .code     (CODE),
    .is_digit (is_digit_s),
    .is_term  (is_term_s),
    .value    (value_s)
  );

  assign CODE_READY = (state_r != HOLD);
  assign acc_s      = CODE_VALID & CODE_READY;

  // Candidate accumulator values for the current byte.
  always_comb begin
    next_number_s  = mul10_add(number_r, value_s);
    next_digits_s  = {digits_r[4*MAX_DIGITS-5:0], value_s};
    first_number_s = {{(VAL_W-4){1'b0}}, value_s};
    first_digits_s = {{(4*MAX_DIGITS-4){1'b0}}, value_s};
    count_full_s   = (count_r >= CNT_W'(MAX_DIGITS));
  end

  // Parser FSM with accumulator, result handshake and error pulse.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r     <= IDLE;
      number_r    <= {VAL_W{1'b0}};
      digits_r    <= {(4*MAX_DIGITS){1'b0}};
      count_r     <= {CNT_W{1'b0}};
      num_valid_r <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            if (is_digit_s) begin
              number_r <= first_number_s;
              digits_r <= first_digits_s;
              count_r  <= CNT_W'(1);
              state_r  <= ACCUM;
            end else if (is_term_s) begin
              state_r <= IDLE;
            end else begin
              error_r <= 1'b1;
              state_r <= SKIP;
            end
          end
        end
        ACCUM: begin
          if (acc_s) begin
            if (is_digit_s && !count_full_s) begin
              number_r <= next_number_s;
              digits_r <= next_digits_s;
              count_r  <= count_r + CNT_W'(1);
            end else if (is_term_s) begin
              num_valid_r <= 1'b1;
              state_r     <= HOLD;
            end else begin
              // Overflow digit or illegal byte: discard the rest of the field.
              error_r <= 1'b1;
              state_r <= SKIP;
            end
          end
        end
        HOLD: begin
          if (NUM_ACK) begin
            num_valid_r <= 1'b0;
            number_r    <= {VAL_W{1'b0}};
            digits_r    <= {(4*MAX_DIGITS){1'b0}};
            count_r     <= {CNT_W{1'b0}};
            state_r     <= IDLE;
          end
        end
        SKIP: begin
          if (acc_s && is_term_s) begin
            number_r <= {VAL_W{1'b0}};
            digits_r <= {(4*MAX_DIGITS){1'b0}};
            count_r  <= {CNT_W{1'b0}};
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign NUMBER      = number_r;
  assign DIGITS      = digits_r;
  assign DIGIT_COUNT = count_r;
  assign NUM_VALID   = num_valid_r;
  assign ERROR       = error_r;

endmodule

// File: tb/tb_code_to_number_parser.sv
// Directed plus randomized bench for code_to_number_parser, checked against
// a field-level model (list of digits, skip flag, held-result flag).
module tb_code_to_number_parser;

  localparam int MAXD = 4;
  localparam int VW   = 14;
  localparam int CW   = 3;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic [7:0]      CODE = 8'h00;
  logic            CODE_VALID = 1'b0;
  logic            NUM_ACK = 1'b0;
  logic            CODE_READY;
  logic [VW-1:0]   NUMBER;
  logic [4*MAXD-1:0] DIGITS;
  logic [CW-1:0]   DIGIT_COUNT;
  logic            NUM_VALID;
  logic            ERROR;

  int checks = 0;
  int errors = 0;

  // Model: digits of the current field, most significant first.
  int fld[$];
  bit skipping = 1'b0;
  bit holding  = 1'b0;
  bit exp_err  = 1'b0;

  code_to_number_parser #(.MAX_DIGITS(MAXD), .VAL_W(VW), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .CODE        (CODE),
    .CODE_VALID  (CODE_VALID),
    .CODE_READY  (CODE_READY),
    .NUMBER      (NUMBER),
    .DIGITS      (DIGITS),
    .DIGIT_COUNT (DIGIT_COUNT),
    .NUM_VALID   (NUM_VALID),
    .NUM_ACK     (NUM_ACK),
    .ERROR       (ERROR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_number();
    int v = 0;
    foreach (fld[i]) v = v * 10 + fld[i];
    return v;
  endfunction

  function automatic logic [31:0] model_digits();
    logic [31:0] d = 32'd0;
    for (int i = 0; i < fld.size(); i++) d[4*i +: 4] = 4'(fld[fld.size()-1-i]);
    return d;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".number"}, 32'(NUMBER), model_number());
    chk({tag, ".digits"}, 32'(DIGITS), model_digits());
    chk({tag, ".count"},  32'(DIGIT_COUNT), fld.size());
    chk({tag, ".valid"},  32'(NUM_VALID), 32'(holding));
    chk({tag, ".error"},  32'(ERROR), 32'(exp_err));
    chk({tag, ".ready"},  32'(CODE_READY), 32'(!holding));
  endtask

  task automatic model_accept(input logic [7:0] b);
    bit is_dig;
    bit is_trm;
    is_dig  = (b >= 8'h30) && (b <= 8'h39);
    is_trm  = (b == 8'h20) || (b == 8'h0D);
    exp_err = 1'b0;
    if (skipping) begin
      if (is_trm) begin
        skipping = 1'b0;
        fld.delete();
      end
    end else if (is_dig) begin
      if (fld.size() < MAXD) fld.push_back(int'(b) - 48);
      else begin
        exp_err  = 1'b1;
        skipping = 1'b1;
      end
    end else if (is_trm) begin
      if (fld.size() > 0) holding = 1'b1;
    end else begin
      exp_err  = 1'b1;
      skipping = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    int n = 0;
    CODE = b;
    CODE_VALID = 1'b1;
    while (!CODE_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, ".ready_wait"}, 32'(n < 20), 32'd1);
    @(negedge CLK);
    CODE_VALID = 1'b0;
    model_accept(b);
    check_all(tag);
  endtask

  task automatic send_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) send(s[i], $sformatf("%s[%0d]", tag, i));
  endtask

  task automatic do_ack(input string tag);
    exp_err = 1'b0;
    NUM_ACK = 1'b1;
    @(negedge CLK);
    NUM_ACK = 1'b0;
    holding = 1'b0;
    fld.delete();
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    RSTN = 1'b0;
    CODE = 8'h39;
    CODE_VALID = 1'b1;
    @(negedge CLK);
    RSTN = 1'b1;
    CODE_VALID = 1'b0;
    fld.delete();
    skipping = 1'b0;
    holding  = 1'b0;
    exp_err  = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 60) return 8'(48 + $urandom_range(0, 9));
    if (r < 75) return 8'h20;
    if (r < 85) return 8'h0D;
    b = 8'h41;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      if (!((b >= 8'h30 && b <= 8'h39) || b == 8'h20 || b == 8'h0D)) break;
      b = 8'h41;
    end
    return b;
  endfunction

  initial begin
    repeat (3) @(negedge CLK);
    check_all("reset");
    RSTN = 1'b1;

    send_str("123 ", "t1");
    chk("t1.number_const", 32'(NUMBER), 32'd123);
    chk("t1.digits_const", 32'(DIGITS), 32'h0123);
    do_ack("t1.ack");

    send_str("9999\r", "t2a");
    chk("t2a.number_const", 32'(NUMBER), 32'd9999);
    do_ack("t2a.ack");
    send_str("12345 ", "t2b");
    send_str("7 ", "t2c");
    chk("t2c.number_const", 32'(NUMBER), 32'd7);
    do_ack("t2c.ack");

    send_str("4A2 ", "t3");

    send_str("  007 ", "t4");
    chk("t4.digits_const", 32'(DIGITS), 32'h0007);
    chk("t4.count_const", 32'(DIGIT_COUNT), 32'd3);
    do_ack("t4.ack");

    // Backpressure: '5' waits through HOLD, ack on the third cycle.
    send_str("8 ", "bp");
    CODE = 8'h35;
    CODE_VALID = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check_all($sformatf("bp.hold%0d", k));
    end
    NUM_ACK = 1'b1;
    @(negedge CLK);
    NUM_ACK = 1'b0;
    holding = 1'b0;
    fld.delete();
    check_all("bp.acked");
    @(negedge CLK);
    CODE_VALID = 1'b0;
    model_accept(8'h35);
    check_all("bp.accept5");
    NUM_ACK = 1'b1;
    @(negedge CLK);
    NUM_ACK = 1'b0;
    exp_err = 1'b0;
    check_all("bp.stray_ack");
    send(8'h20, "bp.term");
    chk("bp.number_const", 32'(NUMBER), 32'd5);
    do_ack("bp.ack");

    send_str("12", "t6a");
    do_reset("t6.reset_mid");
    send_str("3 ", "t6b");
    chk("t6b.number_const", 32'(NUMBER), 32'd3);
    chk("t6b.count_const", 32'(DIGIT_COUNT), 32'd1);
    do_reset("t6.reset_hold");

    for (int i = 0; i < 300; i++) begin
      send(rand_byte(), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 49) == 0) do_reset($sformatf("rnd%0d.reset", i));
      if (holding) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge CLK);
          exp_err = 1'b0;
          check_all($sformatf("rnd%0d.wait", i));
        end
        do_ack($sformatf("rnd%0d.ack", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
